seq_serializer: RTL and testbench
=================================

SEQ_SERIALIZER -- requirements
Module: seq_serializer

Interface
REQ-001 Parameter WIDTH, default 8, word width in bits; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1; 1 = bit WIDTH-1 is sent first, 0 = bit 0 is sent first.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 din  input  WIDTH  parallel word to serialize.
REQ-006 din_valid  input  1  din holds a word to transfer.
REQ-007 din_ready  output  1  block can accept a word this cycle.
REQ-008 seq  output  1  serial bit stream to the downstream sequence detector; 0 when idle.
REQ-009 seq_valid  output  1  seq carries a data bit this cycle.
REQ-010 last  output  1  seq carries the final bit of a word this cycle.

Function
REQ-011 A word SHALL transfer on a rising edge when din_valid=1 and din_ready=1, and only then.
REQ-012 Holding register: one entry (hold, hold_full); din_ready SHALL equal !hold_full, driven from registered state with no combinational path from din_valid.
REQ-013 Shifter: register sr, bit counter cnt (0..WIDTH-1), state in {IDLE, SHIFT}.
REQ-014 IDLE with hold_full=1: next edge loads sr<=hold, clears hold_full, sets cnt<=0, enters SHIFT.
REQ-015 IDLE with hold_full=0: remains IDLE.
REQ-016 SHIFT, cnt<WIDTH-1: next edge shifts sr one position toward the output bit and sets cnt<=cnt+1.
REQ-017 SHIFT, cnt=WIDTH-1, hold_full=1: next edge reloads sr from hold, clears hold_full, sets cnt<=0, stays in SHIFT, so words stream with no gap bit.
REQ-018 SHIFT, cnt=WIDTH-1, hold_full=0: next edge enters IDLE.
REQ-019 seq SHALL be sr[WIDTH-1] (MSB_FIRST=1) or sr[0] (MSB_FIRST=0) in SHIFT, and 0 in IDLE; all outputs are registered or decoded from registers only.
REQ-020 seq_valid SHALL be 1 exactly when state=SHIFT; last SHALL be 1 exactly when state=SHIFT and cnt=WIDTH-1.
REQ-021 Latency: a word accepted at edge T with the shifter idle produces its first bit in the cycle after edge T+1 and its last bit WIDTH-1 cycles later.
REQ-022 Accept while the hold register drains: not possible, because ready=0 while hold_full=1. Refill occurs on the cycle after the drain, which sustains full rate for WIDTH>=2.
REQ-023 Holding full while the shifter is busy: din_ready=0. din and din_valid are ignored and no word is lost or overwritten.
REQ-024 Counter wrap: cnt never exceeds WIDTH-1. An illegal state SHALL recover to IDLE on the next edge with hold contents preserved.

Reset
REQ-025 When reset=1 at an edge: state<=IDLE, cnt<=0, sr<=0, hold_full<=0, hold<=0.
REQ-026 During and after reset: seq=0, seq_valid=0, last=0, din_ready=1.
REQ-027 Reset asserted mid-word SHALL discard the partial word and any held word. The first bit after reset deassertion is the first bit of a newly accepted word.
REQ-028 Reset SHALL take priority over every transfer in the same cycle.

Structure
REQ-029 The state encoding (IDLE, SHIFT) and the default WIDTH constant SHALL live in the shared package used by the sequence-detection blocks.
REQ-030 Single module, no sub-modules. It is instantiated directly upstream of the sequence detector, with seq connected to the detector's seq input.

Verification
REQ-031 Reset, then send din=8'h92 with MSB_FIRST=1 -> seq=1,0,0,1,0,0,1,0 on 8 consecutive cycles with seq_valid=1 and last=1 on the 8th; a downstream 10010 detector flags once.
REQ-032 Send 8'h92 with MSB_FIRST=0 -> seq=0,1,0,0,1,0,0,1.
REQ-033 Hold din_valid=1 with words 8'hA5, 8'h3C, 8'hFF -> 24 contiguous seq_valid cycles with no gap, and last pulses at cycles 8, 16 and 24.
REQ-034 Send 8'hF0, then present 8'h0F while hold_full=1 -> din_ready=0 until the hold register drains, and 8'h0F is sent intact after 8'hF0.
REQ-035 Assert reset on the 4th bit of 8'hC3 while a word is held -> next cycle seq_valid=0 and din_ready=1, and neither word reappears.
REQ-036 Idle for 10 cycles -> seq=0 and seq_valid=0 throughout.

Source files
------------

// File: rtl/seq_serializer_pkg.sv
// rtl/seq_serializer_pkg.sv - shared constants and state encoding for the sequence-detection blocks
//
// Purpose: holds the serializer state encoding and the default word width so
//          the serializer and the downstream sequence detector agree on both.
// Ports:   none (package).
package seq_serializer_pkg;

  localparam int SEQ_WIDTH_DEFAULT = 8;

  // Two bits wide on purpose: leaves unused codes that the serializer treats
  // as illegal and steers back to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01
  } seq_state_e;

endpackage

// File: rtl/seq_serializer.sv
// rtl/seq_serializer.sv - parallel-to-serial word shifter with a one-entry holding register
//
// Purpose: accepts WIDTH-bit words on a valid/ready handshake and emits them
//          one bit per cycle, back to back with no gap when a word is held.
// Ports:
//   clk        in   sole clock, rising edge
//   reset      in   synchronous, active-high
//   din        in   [WIDTH-1:0] parallel word
//   din_valid  in   din holds a word
//   din_ready  out  holding register empty, word can be taken this cycle
//   seq        out  serial bit, 0 when idle
//   seq_valid  out  seq carries a data bit
//   last       out  seq carries the final bit of a word
module seq_serializer
  import seq_serializer_pkg::*;
#(
  parameter int WIDTH     = SEQ_WIDTH_DEFAULT,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             seq,
  output logic             seq_valid,
  output logic             last
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  seq_state_e       state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             hold_full_q, hold_full_d;
  logic             accept;
  logic             load;

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    load        = 1'b0;
    // Ready depends only on hold_full_q, so there is no din_valid -> din_ready path.
    accept      = din_valid && !hold_full_q;

    case (state_q)
      ST_IDLE: begin
        if (hold_full_q) begin
          load = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == CNT_LAST) begin
          // Reload straight from hold on the last bit so words stream gap-free.
          if (hold_full_q) begin
            load = 1'b1;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end else if (cnt_q < CNT_LAST) begin
          sr_d  = MSB_FIRST ? {sr_q[WIDTH-2:0], 1'b0} : {1'b0, sr_q[WIDTH-1:1]};
          cnt_d = cnt_q + 1'b1;
        end else begin
          // Counter past the end of a word: abandon it, keep whatever is held.
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // load needs hold_full_q=1 and accept needs hold_full_q=0, so they never coincide.
    if (load) begin
      sr_d        = hold_q;
      cnt_d       = '0;
      state_d     = ST_SHIFT;
      hold_full_d = 1'b0;
    end else if (accept) begin
      hold_d      = din;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      sr_q        <= '0;
      cnt_q       <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

  assign din_ready = !hold_full_q;
  assign seq_valid = (state_q == ST_SHIFT);
  assign last      = seq_valid && (cnt_q == CNT_LAST);
  assign seq       = seq_valid && (MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0]);

endmodule

// File: tb/tb_seq_serializer.sv
// tb/tb_seq_serializer.sv - self-checking bench for seq_serializer, MSB-first and LSB-first instances
module tb_seq_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] din;
  logic         din_valid;
  logic         din_ready_m, seq_m, seq_valid_m, last_m;
  logic         din_ready_l, seq_l, seq_valid_l, last_l;

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  // Schedule model: each accepted word gets an accept edge and the cycle
  // its first bit appears; everything observable follows from that table.
  int           cyc = 0;
  int           last_end = -100;
  bit           acc_flag;
  logic [W-1:0] m_word[$];
  int           m_acc[$];
  int           m_start[$];

  logic vlog[$];
  logic llog[$];
  logic mbits[$];
  logic lbits[$];

  always #5 clk = ~clk;

  seq_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .din_ready(din_ready_m), .seq(seq_m), .seq_valid(seq_valid_m), .last(last_m)
  );

  seq_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .din_ready(din_ready_l), .seq(seq_l), .seq_valid(seq_valid_l), .last(last_l)
  );

  task automatic chk(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%b required=%b", name, cyc, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit model_ready(input int n);
    bit r = 1'b1;
    foreach (m_start[i]) if (m_acc[i] <= n && n < m_start[i]) r = 1'b0;
    return r;
  endfunction

  function automatic void model_out(input int n, input bit msb,
                                    output logic v, output logic s, output logic l);
    int k;
    v = 1'b0; s = 1'b0; l = 1'b0;
    foreach (m_start[i]) begin
      if (n >= m_start[i] && n <= m_start[i] + W - 1) begin
        k = n - m_start[i];
        v = 1'b1;
        l = (k == W - 1);
        s = msb ? m_word[i][W-1-k] : m_word[i][k];
      end
    end
  endfunction

  // Called right after a rising edge: applies that edge to the schedule.
  function automatic void model_edge();
    int e = cyc + 1;
    int st;
    acc_flag = 1'b0;
    if (reset) begin
      m_word.delete(); m_acc.delete(); m_start.delete();
      last_end = -100;
    end else if (din_valid && model_ready(cyc)) begin
      st = (e + 1 > last_end + 1) ? e + 1 : last_end + 1;
      m_word.push_back(din); m_acc.push_back(e); m_start.push_back(st);
      last_end = st + W - 1;
      acc_flag = 1'b1;
    end
    cyc = e;
    while (m_start.size() > 0 && m_start[0] + W < cyc) begin
      void'(m_word.pop_front()); void'(m_acc.pop_front()); void'(m_start.pop_front());
    end
  endfunction

  always @(negedge clk) begin
    logic ev, es, el, elv, els, ell, er;
    if (chk_on) begin
      model_out(cyc, 1'b1, ev, es, el);
      model_out(cyc, 1'b0, elv, els, ell);
      er = model_ready(cyc);
      chk("ready_msb", din_ready_m, er);
      chk("valid_msb", seq_valid_m, ev);
      chk("seq_msb",   seq_m,       es);
      chk("last_msb",  last_m,      el);
      chk("ready_lsb", din_ready_l, er);
      chk("valid_lsb", seq_valid_l, elv);
      chk("seq_lsb",   seq_l,       els);
      chk("last_lsb",  last_l,      ell);
      vlog.push_back(seq_valid_m);
      llog.push_back(last_m);
      if (seq_valid_m) mbits.push_back(seq_m);
      if (seq_valid_l) lbits.push_back(seq_l);
    end
  end

  task automatic step(input logic r, input logic v, input logic [W-1:0] d);
    @(negedge clk);
    reset = r; din_valid = v; din = d;
    @(posedge clk);
    model_edge();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
  endtask

  // Holds din_valid with the word until the schedule says it was taken.
  task automatic send(input logic [W-1:0] d, output int tries);
    tries = 0;
    do begin
      step(1'b0, 1'b1, d);
      tries++;
    end while (!acc_flag && tries < 64);
    if (!acc_flag) begin
      n_vec++; n_err++;
      $display("FAIL send_timeout word=%0h tries=%0d required=accepted", d, tries);
    end
  endtask

  task automatic clear_logs();
    vlog.delete(); llog.delete(); mbits.delete(); lbits.delete();
  endtask

  function automatic logic [31:0] pack(input logic q[$]);
    logic [31:0] r = '0;
    foreach (q[i]) r = {r[30:0], q[i]};
    return r;
  endfunction

  function automatic int count_ones(input logic q[$]);
    int c = 0;
    foreach (q[i]) if (q[i] === 1'b1) c++;
    return c;
  endfunction

  initial begin
    int tries;
    int f, run;
    reset = 1'b1; din_valid = 1'b0; din = '0;
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    chk_on = 1'b1;
    #2;
    chk("reset_ready", din_ready_m, 1'b1);
    chk("reset_valid", seq_valid_m, 1'b0);
    chk("reset_seq",   seq_m,       1'b0);

    // Single word 0x92 on both bit orders.
    clear_logs();
    send(8'h92, tries);
    idle(12);
    chk32("msb_92_bits",  pack(mbits), 32'h92);
    chk32("lsb_92_bits",  pack(lbits), 32'h49);
    chk32("msb_92_count", mbits.size(), 8);
    chk32("msb_92_lasts", count_ones(llog), 1);

    // Three words with valid held high: one unbroken 24-bit burst.
    clear_logs();
    send(8'hA5, tries);
    send(8'h3C, tries);
    send(8'hFF, tries);
    idle(30);
    f = -1;
    foreach (vlog[i]) if (f < 0 && vlog[i] === 1'b1) f = i;
    run = 0;
    if (f >= 0) while (f + run < vlog.size() && vlog[f+run] === 1'b1) run++;
    chk32("stream_run", run, 24);
    chk32("stream_bits", pack(mbits), 32'hA53CFF);
    chk32("stream_lasts", count_ones(llog), 3);
    if (f >= 0 && f + 23 < llog.size()) begin
      chk("stream_last8",  llog[f+7],  1'b1);
      chk("stream_last16", llog[f+15], 1'b1);
      chk("stream_last24", llog[f+23], 1'b1);
    end else begin
      n_vec++; n_err++;
      $display("FAIL stream_window first=%0d size=%0d required=24 valid cycles", f, llog.size());
    end

    // Second word presented while the first is still held.
    clear_logs();
    send(8'hF0, tries);
    send(8'h0F, tries);
    chk32("backpressure_tries", tries, 2);
    idle(20);
    chk32("backpressure_bits", pack(mbits), 32'hF00F);

    // Reset on the 4th bit of 0xC3 with 0x5A held.
    clear_logs();
    send(8'hC3, tries);
    send(8'h5A, tries);
    idle(2);
    step(1'b1, 1'b1, 8'h77);
    #2;
    chk("midreset_valid", seq_valid_m, 1'b0);
    chk("midreset_ready", din_ready_m, 1'b1);
    chk("midreset_seq",   seq_m,       1'b0);
    clear_logs();
    idle(12);
    chk32("midreset_no_bits", mbits.size(), 0);
    chk32("idle_no_valid", count_ones(vlog), 0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), W'($urandom));
    end
    idle(12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
